// File: rtl/reg_file.sv
// 32 x DW register file with optional write-to-read forwarding, plus the
// syscall display/halt side-channel that snoops the effective v0 (r2) and a0 (r4).
module reg_file #(
    parameter int DW     = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [4:0]    wa,
    input  logic [DW-1:0] wd,
    input  logic [4:0]    ra1,
    input  logic [4:0]    ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          syscall,
    output logic          halt,
    output logic [DW-1:0] disp,
    output logic          disp_valid
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [DW-1:0] regs_reg [0:31];
    logic [31:0]   wen;
    logic          wr_hit;
    logic [DW-1:0] v0_eff;
    logic [DW-1:0] a0_eff;

    state_t        state_reg;
    state_t        state_next;
    logic [DW-1:0] disp_reg;
    logic [DW-1:0] disp_next;
    logic          disp_valid_reg;
    logic          disp_valid_next;

    // A write held under reset is not a write: it neither lands nor forwards.
    assign wr_hit = we && rst_n && (wa != 5'd0);

    for (genvar gi = 0; gi < 32; gi++) begin : g_wen
        assign wen[gi] = wr_hit && (wa == 5'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wen[i]) begin
                    regs_reg[i] <= wd;
                end
            end
        end
    end

    always_comb begin
        rd1 = regs_reg[ra1];
        if (BYPASS && wen[ra1]) begin
            rd1 = wd;
        end
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs_reg[ra2];
        if (BYPASS && wen[ra2]) begin
            rd2 = wd;
        end
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end
    end

    // The syscall always sees the in-flight WB value, whatever BYPASS says.
    assign v0_eff = wen[2] ? wd : regs_reg[2];
    assign a0_eff = wen[4] ? wd : regs_reg[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            disp_reg       <= '0;
            disp_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            disp_reg       <= disp_next;
            disp_valid_reg <= disp_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        disp_next       = disp_reg;
        disp_valid_next = 1'b0;
        if (state_reg == ST_RUN && syscall) begin
            if (v0_eff == DW'(10)) begin
                state_next = ST_HALT;
            end else begin
                disp_next       = a0_eff;
                disp_valid_next = 1'b1;
            end
        end
    end

    assign halt       = (state_reg == ST_HALT);
    assign disp       = disp_reg;
    assign disp_valid = disp_valid_reg;

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DW, 32, data width of every register and of the read and write data ports.
REQ-002 Parameter: BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only.
REQ-003 The block SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 we  input  1  write enable from the WB stage.
REQ-007 wa  input  5  write register index.
REQ-008 wd  input  DW  write data, i.e. the selected WB result (ALU, load byte, load word, pc+4 or immediate).
REQ-009 ra1, ra2  input  5 each  read register indices from ID.
REQ-010 rd1, rd2  output  DW each  combinational read data.
REQ-011 syscall  input  1  WB-stage syscall strobe, one cycle per retired syscall.
REQ-012 halt  output  1  sticky halt flag to the pipeline control.
REQ-013 disp  output  DW  last value displayed by syscall.
REQ-014 disp_valid  output  1  one-cycle pulse when disp updates.

Function
REQ-015 Storage SHALL be 32 registers x DW; r0 SHALL read 0 at all times, and writes to wa=0 SHALL be discarded.
REQ-016 A write SHALL occur on the rising clk edge when we=1 and wa!=0; with we=0, no register changes.
REQ-017 rdN SHALL be combinational from raN; when raN=0, rdN=0.
REQ-018 With BYPASS=1, when we=1, wa!=0 and raN==wa, rdN SHALL equal wd in the same cycle (write-before-read); ra1 and ra2 are forwarded independently.
REQ-019 With BYPASS=0, rdN SHALL return the stored value; the new value is visible from the cycle after the edge.
REQ-020 Effective v0 and a0 SHALL be r2 and r4 with the REQ-018 forwarding applied, regardless of BYPASS.
REQ-021 On a clk edge with syscall=1 and halt=0, if effective v0 == 10, halt SHALL go to 1 on that edge.
REQ-022 On a clk edge with syscall=1 and halt=0, if effective v0 != 10, disp SHALL load effective a0 on that edge, and disp_valid SHALL be 1 for exactly the following cycle.
REQ-023 disp_valid SHALL be 0 in every cycle not covered by REQ-022; back-to-back syscalls SHALL produce back-to-back pulses with an updated disp each cycle.
REQ-024 Once halt=1, it SHALL stay 1 until reset; further syscalls SHALL be ignored, and disp and disp_valid SHALL hold at disp unchanged and disp_valid=0.
REQ-025 Register writes SHALL continue while halt=1; the pipeline gates we upstream.
REQ-026 A write and a syscall in the same cycle SHALL both take effect; the syscall uses the forwarded values per REQ-020.

Reset
REQ-027 rst_n=0 SHALL immediately clear all 32 registers to 0, halt to 0, disp to 0 and disp_valid to 0, independent of clk.
REQ-028 While rst_n=0, writes and syscalls SHALL be ignored.
REQ-029 Deassertion SHALL be synchronised externally; the first write is honoured on the first rising edge with rst_n=1.
REQ-030 Reset asserted mid-operation, including the cycle of a write or syscall, SHALL discard that operation.

Verification
REQ-031 Write wa=5, wd=0xDEADBEEF, we=1 with ra1=5 -> rd1=0xDEADBEEF in the same cycle (BYPASS=1), and in the next cycle with we=0.
REQ-032 Write wa=0, wd=0x12345678 -> rd1 with ra1=0 stays 0 in the same cycle and in all later cycles.
REQ-033 r2=1, r4=0x0000002A, then syscall=1 -> disp=0x2A and disp_valid high for exactly one cycle; halt stays 0.
REQ-034 Same cycle: we=1, wa=2, wd=10 and syscall=1 -> halt=1 after that edge; a later syscall with r2=1 leaves disp unchanged and disp_valid=0.
REQ-035 Write r7=0xFFFFFFFF, then pulse rst_n low between clock edges -> rd1 for ra1=7 becomes 0 immediately, and halt=0, disp=0, disp_valid=0.
REQ-036 Random we/wa/wd/ra1/ra2 sequence over 10k cycles, checked against a reference model -> all reads match, including same-address forwarding and wa=0 discards.
